// File: rtl/tcdm_model_memory.sv
//-----------------------------------------------------------------------------
// tcdm_model_memory
//
// Multi-port, word-addressed TCDM memory model. It sits behind the SoftEx
// accelerator and the Ibex core in the accelerator test system and serves
// data, instruction and stack traffic. Every port is fully independent:
// there is no arbitration between ports. Each port can optionally be stalled
// pseudo-randomly, and each port counts the reads and writes it has granted.
//
// The storage array is named `memory` so that a testbench can preload it and
// read it back hierarchically. Reset does not clear it.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous, active-low reset
//   clk_delayed_i  reserved, ignored
//   randomize_i    read responses return {lfsr, lfsr} instead of memory data
//   enable_i       0 = no grants, no accesses
//   stallable_i    1 = random stalling according to PROB_STALL
//   tcdm_req       [MP]     per-port request
//   tcdm_add       [MP*32]  per-port byte address
//   tcdm_wen       [MP]     1 = read, 0 = write
//   tcdm_be        [MP*4]   per-port byte enables
//   tcdm_data      [MP*32]  per-port write data
//   tcdm_gnt       [MP]     per-port grant (combinational)
//   tcdm_r_data    [MP*32]  per-port response data (registered)
//   tcdm_r_valid   [MP]     per-port response valid (registered)
//   cnt_rd         [MP*32]  per-port granted-read counters
//   cnt_wr         [MP*32]  per-port granted-write counters
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tcdm_model_memory #(
   parameter int unsigned MP          = 1,
   parameter int unsigned MEMORY_SIZE = 196608,
   parameter logic [31:0] BASE_ADDR   = 32'h1c010000,
   parameter real         PROB_STALL  = 0.0,
   parameter realtime     TCP         = 1ns,
   parameter realtime     TA          = 0.2ns,
   parameter realtime     TT          = 0.8ns
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_delayed_i,
   input  logic              randomize_i,
   input  logic              enable_i,
   input  logic              stallable_i,
   input  logic [MP-1:0]     tcdm_req,
   input  logic [MP*32-1:0]  tcdm_add,
   input  logic [MP-1:0]     tcdm_wen,
   input  logic [MP*4-1:0]   tcdm_be,
   input  logic [MP*32-1:0]  tcdm_data,
   output logic [MP-1:0]     tcdm_gnt,
   output logic [MP*32-1:0]  tcdm_r_data,
   output logic [MP-1:0]     tcdm_r_valid,
   output logic [MP*32-1:0]  cnt_rd,
   output logic [MP*32-1:0]  cnt_wr
);

   localparam int unsigned MEM_WORDS = MEMORY_SIZE / 4;
   localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   // A port stalls when its LFSR value is below floor(PROB_STALL * 65536).
   // 17 bits so that PROB_STALL = 1.0 (threshold 65536) stalls every cycle.
   localparam logic [16:0] STALL_THR = 17'($rtoi(PROB_STALL * 65536.0));

   // The clock timing parameters only matter to simulation-side code that
   // shares this parameter list; they have no effect on the logic here.
   if (TCP < 0.0 || TA < 0.0 || TT < 0.0) begin : g_unused_timing
   end

   logic unused_clk_delayed;
   assign unused_clk_delayed = clk_delayed_i;

   //--------------------------------------------------------------------------
   // Storage. Not reset, so back-door preloads survive rst_n.
   //--------------------------------------------------------------------------
   logic [31:0] memory [MEM_WORDS];

   //--------------------------------------------------------------------------
   // Per-port state
   //--------------------------------------------------------------------------
   logic [MP-1:0][15:0]      lfsr_q,    lfsr_d;
   logic [MP-1:0]            r_valid_q, r_valid_d;
   logic [MP-1:0][31:0]      r_data_q,  r_data_d;
   logic [MP-1:0][31:0]      cnt_rd_q,  cnt_rd_d;
   logic [MP-1:0][31:0]      cnt_wr_q,  cnt_wr_d;

   logic [MP-1:0]            stall;
   logic [MP-1:0]            gnt;
   logic [MP-1:0]            rd_acc;
   logic [MP-1:0]            wr_acc;
   logic [MP-1:0][IDX_W-1:0] word_idx;

   //--------------------------------------------------------------------------
   // Handshake: a port's access happens in the cycle where req and gnt are
   // both 1. gnt never waits on other ports. Exactly one cycle after every
   // granted access (read or write) r_valid is 1; r_data carries the read
   // word, or 0 for a write acknowledge, and holds otherwise.
   //--------------------------------------------------------------------------
   always_comb begin
      word_idx = '0;
      stall    = '0;
      gnt      = '0;
      rd_acc   = '0;
      wr_acc   = '0;
      lfsr_d   = lfsr_q;
      for (int i = 0; i < MP; i++) begin
         // Offset is taken modulo the word count, so any address outside the
         // window wraps into the array instead of being rejected.
         word_idx[i] = IDX_W'(((tcdm_add[i*32 +: 32] - BASE_ADDR) >> 2) % MEM_WORDS);

         stall[i]  = stallable_i & ({1'b0, lfsr_q[i]} < STALL_THR);
         gnt[i]    = tcdm_req[i] & enable_i & ~stall[i];
         rd_acc[i] = gnt[i] &  tcdm_wen[i];
         wr_acc[i] = gnt[i] & ~tcdm_wen[i];

         // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
         lfsr_d[i] = {lfsr_q[i][0] ^ lfsr_q[i][2] ^ lfsr_q[i][3] ^ lfsr_q[i][5],
                      lfsr_q[i][15:1]};
      end
   end

   always_comb begin
      r_valid_d = gnt;
      r_data_d  = r_data_q;
      cnt_rd_d  = cnt_rd_q;
      cnt_wr_d  = cnt_wr_q;
      for (int i = 0; i < MP; i++) begin
         if (wr_acc[i]) begin
            r_data_d[i] = '0;
            cnt_wr_d[i] = cnt_wr_q[i] + 32'd1;
         end else if (rd_acc[i]) begin
            // The array read is combinational on the pre-edge contents, so a
            // same-cycle write from another port is not visible here.
            r_data_d[i] = randomize_i ? {lfsr_q[i], lfsr_q[i]} : memory[word_idx[i]];
            cnt_rd_d[i] = cnt_rd_q[i] + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_q <= '0;
         r_data_q  <= '0;
         cnt_rd_q  <= '0;
         cnt_wr_q  <= '0;
         for (int i = 0; i < MP; i++) begin
            lfsr_q[i] <= 16'hACE1 ^ 16'(i);
         end
      end else begin
         r_valid_q <= r_valid_d;
         r_data_q  <= r_data_d;
         cnt_rd_q  <= cnt_rd_d;
         cnt_wr_q  <= cnt_wr_d;
         lfsr_q    <= lfsr_d;
      end
   end

   //--------------------------------------------------------------------------
   // Memory writes. Ports are visited in ascending order, so when several
   // ports write the same byte in one cycle the highest port index wins.
   //--------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      for (int i = 0; i < MP; i++) begin
         if (wr_acc[i]) begin
            for (int b = 0; b < 4; b++) begin
               if (tcdm_be[i*4 + b]) begin
                  memory[word_idx[i]][b*8 +: 8] <= tcdm_data[i*32 + b*8 +: 8];
               end
            end
         end
      end
   end

   //--------------------------------------------------------------------------
   // Outputs
   //--------------------------------------------------------------------------
   assign tcdm_gnt     = gnt;
   assign tcdm_r_valid = r_valid_q;
   assign tcdm_r_data  = r_data_q;
   assign cnt_rd       = cnt_rd_q;
   assign cnt_wr       = cnt_wr_q;

endmodule

// File: tb/tb_tcdm_model_memory.sv
//-----------------------------------------------------------------------------
// tb_tcdm_model_memory
//
// dut_a: 9 ports, default memory size, never stalls. Exercised with a table of
//        single-port vectors and hand-written multi-port / enable / reset
//        sequences.
// dut_b: 2 ports, small memory, PROB_STALL = 0.5. Exercised with random
//        traffic against a reference model (word array, LFSR stepped with
//        plain shifts, expected-response queues).
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tcdm_model_memory;

   localparam int          MPA   = 9;
   localparam int          MEM_A = 196608;
   localparam int          MPB   = 2;
   localparam int          MEM_B = 1024;
   localparam logic [31:0] BASE  = 32'h1c010000;

   //--------------------------------------------------------------------------
   // Clock / reset
   //--------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n;
   logic rst_b_n;
   always #5 clk = ~clk;

   //--------------------------------------------------------------------------
   // DUT signals
   //--------------------------------------------------------------------------
   logic               randomize_a, enable_a, stallable_a;
   logic [MPA-1:0]     req_a, wen_a, gnt_a, r_valid_a;
   logic [MPA*32-1:0]  add_a, data_a, r_data_a, cnt_rd_a, cnt_wr_a;
   logic [MPA*4-1:0]   be_a;

   logic               randomize_b, enable_b, stallable_b;
   logic [MPB-1:0]     req_b, wen_b, gnt_b, r_valid_b;
   logic [MPB*32-1:0]  add_b, data_b, r_data_b, cnt_rd_b, cnt_wr_b;
   logic [MPB*4-1:0]   be_b;

   tcdm_model_memory #(
      .MP(MPA), .MEMORY_SIZE(MEM_A), .BASE_ADDR(BASE), .PROB_STALL(0.0)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .clk_delayed_i(1'b0),
      .randomize_i(randomize_a), .enable_i(enable_a), .stallable_i(stallable_a),
      .tcdm_req(req_a), .tcdm_add(add_a), .tcdm_wen(wen_a), .tcdm_be(be_a),
      .tcdm_data(data_a), .tcdm_gnt(gnt_a), .tcdm_r_data(r_data_a),
      .tcdm_r_valid(r_valid_a), .cnt_rd(cnt_rd_a), .cnt_wr(cnt_wr_a)
   );

   tcdm_model_memory #(
      .MP(MPB), .MEMORY_SIZE(MEM_B), .BASE_ADDR(BASE), .PROB_STALL(0.5)
   ) dut_b (
      .clk(clk), .rst_n(rst_b_n), .clk_delayed_i(1'b0),
      .randomize_i(randomize_b), .enable_i(enable_b), .stallable_i(stallable_b),
      .tcdm_req(req_b), .tcdm_add(add_b), .tcdm_wen(wen_b), .tcdm_be(be_b),
      .tcdm_data(data_b), .tcdm_gnt(gnt_b), .tcdm_r_data(r_data_b),
      .tcdm_r_valid(r_valid_b), .cnt_rd(cnt_rd_b), .cnt_wr(cnt_wr_b)
   );

   //--------------------------------------------------------------------------
   // Scoreboard state
   //--------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   logic [15:0] lfsr_m  [MPB];
   logic [31:0] ref_b   [8];
   logic [31:0] exp_q   [MPB][$];
   logic [31:0] last_rd [MPB];
   logic        exp_g   [MPB];
   int          n_gnt   [MPB];
   int          m_rd    [MPB];
   int          m_wr    [MPB];
   int          b_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   //--------------------------------------------------------------------------
   // Driver tasks
   //--------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      req_a  = '0;
      wen_a  = '1;
      add_a  = '0;
      be_a   = '0;
      data_a = '0;
   endtask

   task automatic idle_b();
      req_b  = '0;
      wen_b  = '1;
      add_b  = '0;
      be_b   = '0;
      data_b = '0;
   endtask

   task automatic drive_a(input int p, input logic req, input logic wen,
                          input logic [31:0] add, input logic [3:0] be,
                          input logic [31:0] data);
      req_a[p]           = req;
      wen_a[p]           = wen;
      add_a[p*32 +: 32]  = add;
      be_a[p*4 +: 4]     = be;
      data_a[p*32 +: 32] = data;
   endtask

   // Reference LFSR: Fibonacci, taps 16,14,13,11, new bit enters at the top.
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      int unsigned v;
      int unsigned fb;
      v  = l;
      fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      v  = (v >> 1) | (fb << 15);
      return 16'(v);
   endfunction

   // One cycle of random traffic on every port of dut_b, checked against the
   // reference model.
   task automatic b_cycle();
      int          wi [MPB];
      logic [31:0] wd [MPB];
      logic [3:0]  wb [MPB];
      logic        rd [MPB];
      logic [31:0] e;
      for (int p = 0; p < MPB; p++) begin
         wi[p] = $urandom_range(0, 7);
         rd[p] = ($urandom_range(0, 1) == 1);
         wd[p] = $urandom;
         wb[p] = 4'($urandom_range(0, 15));
         req_b[p]           = 1'b1;
         wen_b[p]           = rd[p];
         add_b[p*32 +: 32]  = BASE + 32'(wi[p] * 4) +
                              (($urandom_range(0, 1) == 1) ? 32'(MEM_B) : 32'd0);
         be_b[p*4 +: 4]     = wb[p];
         data_b[p*32 +: 32] = wd[p];
      end
      #2;
      for (int p = 0; p < MPB; p++) begin
         exp_g[p] = !(stallable_b && (lfsr_m[p] < 16'h8000));
         check($sformatf("b gnt p%0d c%0d", p, b_cyc), gnt_b[p], exp_g[p]);
         if (gnt_b[p]) n_gnt[p]++;
         if (exp_g[p]) begin
            if (rd[p]) begin
               exp_q[p].push_back(randomize_b ? {lfsr_m[p], lfsr_m[p]} : ref_b[wi[p]]);
               m_rd[p]++;
            end else begin
               exp_q[p].push_back(32'h0);
               m_wr[p]++;
            end
         end
      end
      // Reads above saw the old words; writes land now, later ports overriding.
      for (int p = 0; p < MPB; p++) begin
         if (exp_g[p] && !rd[p]) begin
            for (int b = 0; b < 4; b++) begin
               if (wb[p][b]) ref_b[wi[p]][8*b +: 8] = wd[p][8*b +: 8];
            end
         end
      end
      tick();
      for (int p = 0; p < MPB; p++) begin
         check($sformatf("b r_valid p%0d c%0d", p, b_cyc), r_valid_b[p], exp_g[p]);
         if (exp_q[p].size() > 0) begin
            e = exp_q[p].pop_front();
            check($sformatf("b r_data p%0d c%0d", p, b_cyc), r_data_b[p*32 +: 32], e);
            last_rd[p] = e;
         end else begin
            check($sformatf("b r_data hold p%0d c%0d", p, b_cyc), r_data_b[p*32 +: 32], last_rd[p]);
         end
         lfsr_m[p] = lfsr_step(lfsr_m[p]);
      end
      b_cyc++;
   endtask

   //--------------------------------------------------------------------------
   // Vector table for port 0 of dut_a (counters are cumulative)
   //--------------------------------------------------------------------------
   typedef struct {
      logic        req;
      logic        wen;
      logic [31:0] add;
      logic [3:0]  be;
      logic [31:0] data;
      logic        exp_gnt;
      logic        exp_rvalid;
      logic [31:0] exp_rdata;
      logic [31:0] exp_rd;
      logic [31:0] exp_wr;
   } vec_t;

   vec_t vecs [11];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] par_val [MPA];

      vecs[0]  = '{1'b1, 1'b1, BASE,                          4'hF, 32'h0,        1'b1, 1'b1, 32'h3C003C00, 32'd1, 32'd0};
      vecs[1]  = '{1'b1, 1'b0, BASE + 32'd4,                  4'h5, 32'hDEADBEEF, 1'b1, 1'b1, 32'h00000000, 32'd1, 32'd1};
      vecs[2]  = '{1'b1, 1'b1, BASE + 32'd4,                  4'hF, 32'h0,        1'b1, 1'b1, 32'h00AD00EF, 32'd2, 32'd1};
      vecs[3]  = '{1'b0, 1'b1, BASE,                          4'hF, 32'h0,        1'b0, 1'b0, 32'h00AD00EF, 32'd2, 32'd1};
      vecs[4]  = '{1'b1, 1'b1, BASE + 32'(MEM_A),             4'hF, 32'h0,        1'b1, 1'b1, 32'h3C003C00, 32'd3, 32'd1};
      vecs[5]  = '{1'b1, 1'b0, BASE + 32'(MEM_A) + 32'd8,     4'hF, 32'h12345678, 1'b1, 1'b1, 32'h00000000, 32'd3, 32'd2};
      vecs[6]  = '{1'b1, 1'b1, BASE + 32'd8,                  4'hF, 32'h0,        1'b1, 1'b1, 32'h12345678, 32'd4, 32'd2};
      vecs[7]  = '{1'b1, 1'b0, BASE + 32'd8,                  4'h8, 32'hAABBCCDD, 1'b1, 1'b1, 32'h00000000, 32'd4, 32'd3};
      vecs[8]  = '{1'b1, 1'b1, BASE + 32'd8,                  4'hF, 32'h0,        1'b1, 1'b1, 32'hAA345678, 32'd5, 32'd3};
      vecs[9]  = '{1'b1, 1'b0, BASE + 32'(2*MEM_A) + 32'd12,  4'hF, 32'hCAFEF00D, 1'b1, 1'b1, 32'h00000000, 32'd5, 32'd4};
      vecs[10] = '{1'b1, 1'b1, BASE + 32'd12,                 4'hF, 32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 32'd6, 32'd4};

      // Reset and initial conditions
      rst_n       = 1'b0;
      rst_b_n     = 1'b0;
      randomize_a = 1'b0;
      enable_a    = 1'b1;
      stallable_a = 1'b0;
      randomize_b = 1'b0;
      enable_b    = 1'b1;
      stallable_b = 1'b1;
      idle_a();
      idle_b();
      dut_a.memory[0] = 32'h3C003C00;
      dut_a.memory[1] = 32'h0;

      tick();
      drive_a(0, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
      #2;
      check("gnt in reset", gnt_a[0], 1'b1);
      tick();
      idle_a();
      check("reset r_valid", r_valid_a, '0);
      check("reset r_data", 32'(|r_data_a), 32'h0);
      check("reset cnt_rd", 32'(|cnt_rd_a), 32'h0);
      check("reset cnt_wr", 32'(|cnt_wr_a), 32'h0);
      check("reset b r_valid", r_valid_b, '0);
      rst_n = 1'b1;
      tick();

      // Table-driven single-port vectors
      for (int k = 0; k < 11; k++) begin
         drive_a(0, vecs[k].req, vecs[k].wen, vecs[k].add, vecs[k].be, vecs[k].data);
         #2;
         check($sformatf("vec%0d gnt", k), gnt_a[0], vecs[k].exp_gnt);
         tick();
         check($sformatf("vec%0d r_valid", k), r_valid_a[0], vecs[k].exp_rvalid);
         check($sformatf("vec%0d r_data", k), r_data_a[31:0], vecs[k].exp_rdata);
         check($sformatf("vec%0d cnt_rd", k), cnt_rd_a[31:0], vecs[k].exp_rd);
         check($sformatf("vec%0d cnt_wr", k), cnt_wr_a[31:0], vecs[k].exp_wr);
      end
      idle_a();
      check("backdoor mem1", dut_a.memory[1], 32'h00AD00EF);

      // All nine ports read distinct words in one cycle
      for (int i = 0; i < MPA; i++) begin
         par_val[i] = $urandom;
         dut_a.memory[32 + i] = par_val[i];
         drive_a(i, 1'b1, 1'b1, BASE + 32'((32 + i) * 4), 4'hF, 32'h0);
      end
      #2;
      check("par gnt", gnt_a, 9'h1FF);
      tick();
      idle_a();
      check("par r_valid", r_valid_a, 9'h1FF);
      for (int i = 0; i < MPA; i++) begin
         check($sformatf("par r_data p%0d", i), r_data_a[i*32 +: 32], par_val[i]);
      end
      check("par cnt_rd p0", cnt_rd_a[31:0], 32'd7);
      check("par cnt_rd p8", cnt_rd_a[8*32 +: 32], 32'd1);

      // Same-word writes: port 8 beats port 0; port 5 beats port 3 on its bytes;
      // port 1 reads the word being written and must see the old contents.
      dut_a.memory[4] = 32'h01020304;
      dut_a.memory[5] = 32'h0;
      drive_a(0, 1'b1, 1'b0, BASE + 32'd16, 4'hF, 32'h11111111);
      drive_a(8, 1'b1, 1'b0, BASE + 32'd16, 4'hF, 32'h88888888);
      drive_a(1, 1'b1, 1'b1, BASE + 32'd16, 4'hF, 32'h0);
      drive_a(3, 1'b1, 1'b0, BASE + 32'd20, 4'hF, 32'h33333333);
      drive_a(5, 1'b1, 1'b0, BASE + 32'd20, 4'h3, 32'h55555555);
      tick();
      idle_a();
      check("pre-write read", r_data_a[1*32 +: 32], 32'h01020304);
      check("write ack r_data p8", r_data_a[8*32 +: 32], 32'h0);
      check("write ack r_valid", r_valid_a, 9'b100101011);
      drive_a(2, 1'b1, 1'b1, BASE + 32'd16, 4'hF, 32'h0);
      drive_a(4, 1'b1, 1'b1, BASE + 32'd20, 4'hF, 32'h0);
      tick();
      idle_a();
      check("collide full word", r_data_a[2*32 +: 32], 32'h88888888);
      check("collide byte-wise", r_data_a[4*32 +: 32], 32'h33335555);

      // enable_i = 0 blocks everything
      enable_a = 1'b0;
      drive_a(0, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
      drive_a(6, 1'b1, 1'b0, BASE, 4'hF, 32'hFFFFFFFF);
      #2;
      check("disabled gnt", gnt_a, '0);
      tick();
      idle_a();
      enable_a = 1'b1;
      check("disabled r_valid", r_valid_a, '0);
      check("disabled cnt_rd p0", cnt_rd_a[31:0], 32'd7);
      check("disabled cnt_wr p0", cnt_wr_a[31:0], 32'd5);
      check("disabled cnt_wr p6", cnt_wr_a[6*32 +: 32], 32'd0);

      // Reset in the middle of a stream
      drive_a(0, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
      tick();
      check("pre-reset r_valid", r_valid_a[0], 1'b1);
      drive_a(0, 1'b1, 1'b1, BASE + 32'd8, 4'hF, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst r_valid", r_valid_a, '0);
      check("async rst r_data", 32'(|r_data_a), 32'h0);
      check("async rst cnt_rd", 32'(|cnt_rd_a), 32'h0);
      check("async rst cnt_wr", 32'(|cnt_wr_a), 32'h0);
      idle_a();
      tick();
      rst_n = 1'b1;
      tick();
      check("post-reset r_valid", r_valid_a, '0);
      check("mem retained", dut_a.memory[0], 32'h3C003C00);
      drive_a(0, 1'b1, 1'b1, BASE, 4'hF, 32'h0);
      tick();
      idle_a();
      check("post-reset read valid", r_valid_a[0], 1'b1);
      check("post-reset read data", r_data_a[31:0], 32'h3C003C00);
      check("post-reset cnt_rd", cnt_rd_a[31:0], 32'd1);

      // Random traffic with stalling on dut_b
      for (int w = 0; w < 8; w++) begin
         dut_b.memory[w] = 32'h0;
         ref_b[w]        = 32'h0;
      end
      for (int p = 0; p < MPB; p++) begin
         lfsr_m[p]  = 16'hACE1 ^ 16'(p);
         last_rd[p] = 32'h0;
         n_gnt[p]   = 0;
         m_rd[p]    = 0;
         m_wr[p]    = 0;
      end
      tick();
      rst_b_n = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         randomize_b = (c >= 500);
         b_cycle();
      end
      for (int p = 0; p < MPB; p++) begin
         check_range($sformatf("stall grant rate p%0d", p), n_gnt[p], 400, 600);
         n_gnt[p] = 0;
      end

      stallable_b = 1'b0;
      randomize_b = 1'b0;
      for (int c = 0; c < 50; c++) begin
         b_cycle();
      end
      for (int p = 0; p < MPB; p++) begin
         check_range($sformatf("unstalled grants p%0d", p), n_gnt[p], 50, 50);
      end
      idle_b();
      tick();
      for (int p = 0; p < MPB; p++) begin
         check($sformatf("b cnt_rd p%0d", p), cnt_rd_b[p*32 +: 32], 32'(m_rd[p]));
         check($sformatf("b cnt_wr p%0d", p), cnt_wr_b[p*32 +: 32], 32'(m_wr[p]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tcdm_model_memory.md
Name: tcdm_model_memory

Overview:
- Multi-port, word-addressed TCDM memory model with MP independent ports.
- Used as the data, instruction and stack memory behind the SoftEx (sfm) accelerator and the Ibex core in the accelerator test system.
- Each port uses the hwpe TCDM protocol: req/gnt with a one-cycle response.
- Adds optional pseudo-random grant stalling and per-port read/write access counters.
- The memory array must be back-door loadable and readable through the hierarchical array `memory`.

Parameters:
- MP, 1: number of TCDM ports.
- MEMORY_SIZE, 196608: memory size in bytes; a multiple of 4.
- BASE_ADDR, 32'h1c010000: byte address of memory[0].
- PROB_STALL, 0.0: probability (0.0–1.0) that a requesting stallable port is not granted in a given cycle.
- TCP, 1ns: clock period. Simulation-only; no functional effect in RTL.
- TA, 0.2ns: application time. Simulation-only; no functional effect in RTL.
- TT, 0.8ns: test time. Simulation-only; no functional effect in RTL.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clk_delayed_i  in  1  reserved; ignored.
- randomize_i  in  1  when 1, read responses return LFSR data instead of memory contents.
- enable_i  in  1  when 0, no grants are issued and no accesses are performed.
- stallable_i  in  1  when 1, random stalling per PROB_STALL is active.
- tcdm_req  in  MP  per-port request.
- tcdm_add  in  MP*32  per-port byte address.
- tcdm_wen  in  MP  1 = read, 0 = write.
- tcdm_be  in  MP*4  per-port byte enables.
- tcdm_data  in  MP*32  per-port write data.
- tcdm_gnt  out  MP  per-port grant.
- tcdm_r_data  out  MP*32  per-port response data.
- tcdm_r_valid  out  MP  per-port response valid.
- cnt_rd  out  MP*32  per-port granted-read counters.
- cnt_wr  out  MP*32  per-port granted-write counters.

Behaviour:
- Storage: `memory` is an array of MEMORY_SIZE/4 words, 32 bits each.
  - Word index = ((add - BASE_ADDR) >> 2) mod (MEMORY_SIZE/4); out-of-range addresses wrap.
  - Contents are NOT cleared by reset, so back-door preloads survive reset.
- Grant: gnt[i] = req[i] & enable_i & ~stall[i]. Combinational, with no dependence on other ports and no arbitration.
- Stall generation:
  - stall[i] = stallable_i & (lfsr[i][15:0] < floor(PROB_STALL*65536)).
  - lfsr[i] is a per-port 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded to 16'hACE1 ^ i on reset, and advanced every cycle.
  - PROB_STALL = 0 means never stall.
- Write (req & gnt & ~wen) at the clk rising edge: byte b of the word is updated from data[8b+7:8b] only where be[b] = 1.
- Read (req & gnt & wen):
  - r_data is registered and valid in the next cycle.
  - It returns the pre-write contents when another port writes the same word in the same cycle.
- Response:
  - r_valid[i] is registered to 1 exactly one cycle after every granted access, read or write, so cores that require store acknowledges work.
  - Back-to-back granted accesses give back-to-back r_valid.
  - r_data after a write is 0.
  - r_data holds its value when r_valid = 0.
- Same-word writes from several ports in one cycle: byte-wise, the highest port index wins.
- randomize_i = 1: r_data for reads = {lfsr[i], lfsr[i]}. The memory is still read but the value is discarded.
- Counters: cnt_rd[i] / cnt_wr[i] increment by 1 per granted read / write on port i. They are 32-bit, wrap at 2^32, and are also accessible hierarchically.
- Reset values (async on rst_n = 0): r_valid = 0, r_data = 0, counters = 0, LFSRs = seeds. gnt is combinational and follows the inputs.
- Reset mid-operation: pending responses are dropped (r_valid forced to 0). Memory contents are retained.

Test Plan:
- Back-door load memory[0] = 32'h3C003C00, MP = 1, PROB_STALL = 0. Read 0x1c010000 → gnt same cycle, next cycle r_valid = 1, r_data = 32'h3C003C00, cnt_rd = 1.
- Write 0x1c010004, data 32'hDEADBEEF, be = 4'b0101, over old value 0 → r_valid next cycle. A read then returns 32'h00AD00EF, cnt_wr = 1.
- MP = 9, all ports read distinct words in the same cycle → all 9 gnt = 1, all 9 r_valid = 1 next cycle with the correct data. Port 0 and port 8 both write 0x1c010010 (8'h11 vs 8'h88 in every byte) → word becomes 32'h88888888.
- PROB_STALL = 0.5, stallable_i = 1, continuous requests for 1000 cycles → grant rate 40–60%, and every grant is followed by exactly one r_valid. With stallable_i = 0 → 100% grants.
- enable_i = 0 with req = 1 → gnt = 0, no r_valid, counters unchanged. Assert rst_n = 0 mid-stream → r_valid = 0 and counters = 0 immediately, and preloaded memory[0] is still 32'h3C003C00 afterwards.
- Address 0x1c010000 + MEMORY_SIZE → accesses memory[0] (wrap-around).
